// File: rtl/v_hier_qvec_fifo.sv
// ----------------------------------------------------------------------------
// v_hier_qvec_fifo
//
// Purpose:
//   Sits downstream of the v_hier_sub qvec result bus. Every qvec word marked
//   valid is captured into a small FIFO and handed to a ready/valid consumer.
//   The producer cannot be stalled, so a word that arrives while the FIFO is
//   full is lost and counted. A saturating running sum of accepted words and a
//   saturating drop counter are kept alongside the FIFO and can be cleared
//   without disturbing the queued data.
//
// Ports:
//   clk       in   single clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset; wins over every other input
//   in_vld    in   in_data is valid this cycle (no backpressure)
//   in_data   in   WIDTH-bit qvec word from the upstream stage
//   out_vld   out  FIFO head is valid (FIFO not empty)
//   out_data  out  FIFO head word, forced to 0 while empty
//   out_rdy   in   consumer takes the head when out_vld is high
//   stat_clr  in   synchronous clear of sum and drop_cnt
//   sum       out  saturating sum of accepted words
//   drop_cnt  out  saturating count of words lost to overflow
//   level     out  occupancy, 0..DEPTH
//   full      out  level == DEPTH
//   empty     out  level == 0
// ----------------------------------------------------------------------------
module v_hier_qvec_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SUM_W = 12,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    input  logic             stat_clr,
    output logic [SUM_W-1:0] sum,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Pointers carry one wrap bit above the index so that full and empty can
    // be told apart when the index bits match.
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // ------------------------------------------------------------------------
    // Status and handshake decode
    // ------------------------------------------------------------------------
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic           full_w;
    logic           empty_w;
    logic           push;
    logic           pop;
    logic           drop;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // full is judged on the pre-edge state, so a pop in a full cycle does not
    // free a slot for the word arriving in that same cycle.
    assign push = in_vld & ~full_w;
    assign pop  = ~empty_w & out_rdy;
    assign drop = in_vld & full_w;

    // ------------------------------------------------------------------------
    // Saturating arithmetic
    // ------------------------------------------------------------------------
    // Sum is formed one bit wider than the register so the carry out shows
    // the overflow directly.
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_sat;
    logic [CNT_W-1:0] drop_inc;

    always_comb begin
        sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(in_data);
        if (sum_ext[SUM_W]) begin
            sum_sat = '1;
        end else begin
            sum_sat = sum_ext[SUM_W-1:0];
        end
    end

    always_comb begin
        if (drop_cnt_q == '1) begin
            drop_inc = drop_cnt_q;
        end else begin
            drop_inc = drop_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: FIFO storage and pointers
    // ------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            mem_d[wr_idx] = in_data;
            wr_ptr_d      = wr_ptr_q + LW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: statistics
    // ------------------------------------------------------------------------
    // A clear replaces the old value rather than the update: the current
    // cycle's push or drop still lands on top of the zeroed counter.
    always_comb begin
        sum_d      = sum_q;
        drop_cnt_d = drop_cnt_q;

        if (stat_clr) begin
            sum_d      = push ? SUM_W'(in_data) : '0;
            drop_cnt_d = drop ? CNT_W'(1) : '0;
        end else begin
            if (push) begin
                sum_d = sum_sat;
            end
            if (drop) begin
                drop_cnt_d = drop_inc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sum_q      <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sum_q      <= sum_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        out_vld  = ~empty_w;
        out_data = empty_w ? '0 : mem_q[rd_idx];
        sum      = sum_q;
        drop_cnt = drop_cnt_q;
        level    = wr_ptr_q - rd_ptr_q;
        full     = full_w;
        empty    = empty_w;
    end

endmodule

// File: tb/tb_v_hier_qvec_fifo.sv
// ----------------------------------------------------------------------------
// tb_v_hier_qvec_fifo
//
// Self-checking bench for v_hier_qvec_fifo. A queue-based reference model
// tracks contents, sum and drop count from the behavioural rules; directed
// scenarios check fixed expected values and a randomized phase compares every
// output against the model each cycle.
// ----------------------------------------------------------------------------
module tb_v_hier_qvec_fifo;

    localparam int DEPTH   = 4;
    localparam int SUM_MAX = 4095;
    localparam int CNT_MAX = 255;

    logic       clk;
    logic       reset;
    logic       in_vld;
    logic [3:0] in_data;
    logic       out_vld;
    logic [3:0] out_data;
    logic       out_rdy;
    logic       stat_clr;
    logic [11:0] sum;
    logic [7:0] drop_cnt;
    logic [2:0] level;
    logic       full;
    logic       empty;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [3:0] m_q[$];
    int         m_sum;
    int         m_drops;

    v_hier_qvec_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .stat_clr (stat_clr),
        .sum      (sum),
        .drop_cnt (drop_cnt),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle's worth of model behaviour using pre-edge occupancy.
    task automatic model_step(input logic vld, input logic [3:0] d, input logic rdy,
                              input logic clr, input logic rst);
        bit m_full;
        bit m_empty;
        bit p_push;
        bit p_pop;
        bit p_drop;
        if (rst) begin
            m_q.delete();
            m_sum   = 0;
            m_drops = 0;
            return;
        end
        m_full  = (m_q.size() == DEPTH);
        m_empty = (m_q.size() == 0);
        p_push  = vld && !m_full;
        p_pop   = rdy && !m_empty;
        p_drop  = vld && m_full;
        if (p_pop) void'(m_q.pop_front());
        if (p_push) m_q.push_back(d);
        if (clr) begin
            m_sum   = p_push ? int'(d) : 0;
            m_drops = p_drop ? 1 : 0;
        end else begin
            if (p_push) m_sum = (m_sum + int'(d) > SUM_MAX) ? SUM_MAX : m_sum + int'(d);
            if (p_drop) m_drops = (m_drops + 1 > CNT_MAX) ? CNT_MAX : m_drops + 1;
        end
    endtask

    // Drive inputs at the falling edge, clock once, return at the next falling edge.
    task automatic cycle(input logic vld, input logic [3:0] d, input logic rdy,
                         input logic clr, input logic rst);
        in_vld   = vld;
        in_data  = d;
        out_rdy  = rdy;
        stat_clr = clr;
        reset    = rst;
        @(posedge clk);
        model_step(vld, d, rdy, clr, rst);
        @(negedge clk);
        in_vld   = 1'b0;
        in_data  = 4'h0;
        out_rdy  = 1'b0;
        stat_clr = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (out_vld !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld);
        end
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full);
        end
        n_checks++;
        if (level !== 3'd0 || out_data !== 4'h0) begin
            n_errors++; $display("FAIL reset_level: got level=%0d data=%h want 0/0", level, out_data);
        end
        n_checks++;
        if (sum !== 12'h000 || drop_cnt !== 8'h00) begin
            n_errors++; $display("FAIL reset_stats: got sum=%h drop=%h want 0/0", sum, drop_cnt);
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] words [4];
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'hA; words[3] = 4'hF;
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, words[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (out_vld !== 1'b1 || out_data !== 4'h3) begin
                n_errors++;
                $display("FAIL fill_head_%0d: got vld=%b data=%h want 1/3", i, out_vld, out_data);
            end
        end
        n_checks++;
        if (full !== 1'b1 || level !== 3'd4) begin
            n_errors++; $display("FAIL fill_full: got full=%b level=%0d want 1/4", full, level);
        end
        n_checks++;
        if (sum !== 12'h021) begin
            n_errors++; $display("FAIL fill_sum: got %h want 021", sum);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_data !== words[i]) begin
                n_errors++; $display("FAIL drain_order_%0d: got %h want %h", i, out_data, words[i]);
            end
            cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (empty !== 1'b1 || out_vld !== 1'b0 || out_data !== 4'h0) begin
            n_errors++;
            $display("FAIL drain_empty: got empty=%b vld=%b data=%h want 1/0/0", empty, out_vld, out_data);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd3 || sum !== 12'h021) begin
            n_errors++; $display("FAIL overflow_drops: got drop=%0d sum=%h want 3/021", drop_cnt, sum);
        end
        n_checks++;
        if (level !== 3'd4 || out_data !== 4'h3) begin
            n_errors++; $display("FAIL overflow_keep: got level=%0d head=%h want 4/3", level, out_data);
        end
        // Push+pop while full: pop wins, push refused and counted.
        cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== 3'd3 || drop_cnt !== 8'd4 || out_data !== 4'h5) begin
            n_errors++;
            $display("FAIL full_push_pop: got level=%0d drop=%0d head=%h want 3/4/5", level, drop_cnt, out_data);
        end
        // Push+pop on an empty FIFO: only the push happens.
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== 3'd1 || out_data !== 4'h6) begin
            n_errors++; $display("FAIL empty_push_pop: got level=%0d head=%h want 1/6", level, out_data);
        end
    endtask

    task automatic test_saturate();
        int bad_level;
        bad_level = 0;
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
            if (level !== 3'd1 || out_data !== 4'hF) bad_level++;
        end
        n_checks++;
        if (bad_level != 0) begin
            n_errors++; $display("FAIL stream_level: got %0d bad cycles want 0", bad_level);
        end
        n_checks++;
        if (sum !== 12'hFFF) begin
            n_errors++; $display("FAIL stream_sum_sat: got %h want fff", sum);
        end
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++; $display("FAIL stream_drops: got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_stat_clr();
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 12'd9 || level !== 3'd3) begin
            n_errors++; $display("FAIL clr_push: got sum=%0d level=%0d want 9/3", sum, level);
        end
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd2 || sum !== 12'd10) begin
            n_errors++; $display("FAIL clr_pre: got drop=%0d sum=%0d want 2/10", drop_cnt, sum);
        end
        cycle(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd1 || sum !== 12'd0 || level !== 3'd4) begin
            n_errors++;
            $display("FAIL clr_drop: got drop=%0d sum=%0d level=%0d want 1/0/4", drop_cnt, sum, level);
        end
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd0 || out_data !== 4'h4) begin
            n_errors++; $display("FAIL clr_alone: got drop=%0d head=%h want 0/4", drop_cnt, out_data);
        end
    endtask

    task automatic test_reset_traffic();
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== 3'd3) begin
            n_errors++; $display("FAIL pre_reset_level: got %0d want 3", level);
        end
        // Reset alongside push/pop/clear: reset wins.
        cycle(1'b1, 4'hB, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (empty !== 1'b1 || out_vld !== 1'b0 || level !== 3'd0 || out_data !== 4'h0) begin
            n_errors++;
            $display("FAIL traffic_reset: got empty=%b vld=%b level=%0d data=%h want 1/0/0/0",
                     empty, out_vld, level, out_data);
        end
        n_checks++;
        if (sum !== 12'd0) begin
            n_errors++; $display("FAIL traffic_reset_sum: got %0d want 0", sum);
        end
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (out_vld !== 1'b1 || out_data !== 4'h2) begin
            n_errors++; $display("FAIL post_reset_push: got vld=%b data=%h want 1/2", out_vld, out_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_data;
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0));
            exp_data = (m_q.size() != 0) ? m_q[0] : 4'h0;
            n_checks++;
            if (level !== 3'(m_q.size()) || full !== (m_q.size() == DEPTH) ||
                empty !== (m_q.size() == 0) || out_vld !== (m_q.size() != 0)) begin
                n_errors++;
                $display("FAIL rand_status_%0d: got level=%0d full=%b empty=%b vld=%b want level=%0d",
                         i, level, full, empty, out_vld, m_q.size());
            end
            n_checks++;
            if (out_data !== exp_data) begin
                n_errors++; $display("FAIL rand_data_%0d: got %h want %h", i, out_data, exp_data);
            end
            n_checks++;
            if (sum !== 12'(m_sum) || drop_cnt !== 8'(m_drops)) begin
                n_errors++;
                $display("FAIL rand_stats_%0d: got sum=%0d drop=%0d want %0d/%0d",
                         i, sum, drop_cnt, m_sum, m_drops);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_sum    = 0;
        m_drops  = 0;
        reset    = 1'b1;
        in_vld   = 1'b0;
        in_data  = 4'h0;
        out_rdy  = 1'b0;
        stat_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_saturate();
        test_stat_clr();
        test_reset_traffic();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
